// File: rtl/jb_cntr_pkg.sv
// Shared types for the multi-channel P2S sequence counter.
package jb_cntr_pkg;

    typedef enum logic {CNT_ONESHOT, CNT_CONT} cnt_mode_t;
    typedef enum logic {ST_IDLE, ST_RUN} cnt_state_t;

    localparam int DEF_COUNT_WIDTH = 39;

endpackage

// File: rtl/jb_cntr_p2s_ch.sv
// One counter channel: edge detect, FSM, max/mode shadows and last flag.
// JB_CNTR_P2S_MC_RETRIG_EN: a rising enable during RUN restarts the run.
module jb_cntr_p2s_ch
    import jb_cntr_pkg::*;
#(
    parameter int COUNT_WIDTH = DEF_COUNT_WIDTH
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    input  logic                   stop,
    input  logic                   hold,
    input  logic                   mode,
    input  logic [COUNT_WIDTH-1:0] max_value,
    output logic [COUNT_WIDTH-1:0] cntr,
    output logic                   busy,
    output logic                   last
);

    cnt_state_t             state;
    cnt_mode_t              mode_sh;
    logic [COUNT_WIDTH-1:0] max_sh;
    logic [COUNT_WIDTH-1:0] cntr_inc;
    logic                   enable_d1;
    logic                   start;

    assign start    = enable & ~enable_d1;
    assign cntr_inc = cntr + 1'b1;
    assign busy     = (state == ST_RUN);

    // Terminal compare drives the wrap, so an all-ones max never overflows.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            mode_sh   <= CNT_ONESHOT;
            max_sh    <= '0;
            cntr      <= '0;
            last      <= 1'b0;
            enable_d1 <= 1'b1;
        end else begin
            enable_d1 <= enable;
            unique case (state)
                ST_IDLE: begin
                    if (start && !stop && max_value != '0) begin
                        max_sh  <= max_value;
                        mode_sh <= cnt_mode_t'(mode);
                        cntr    <= COUNT_WIDTH'(1);
                        last    <= (max_value == COUNT_WIDTH'(1));
                        state   <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (stop) begin
                        cntr  <= '0;
                        last  <= 1'b0;
                        state <= ST_IDLE;
                    end
`ifdef JB_CNTR_P2S_MC_RETRIG_EN
                    else if (start) begin
                        max_sh  <= max_value;
                        mode_sh <= cnt_mode_t'(mode);
                        if (max_value != '0) begin
                            cntr <= COUNT_WIDTH'(1);
                            last <= (max_value == COUNT_WIDTH'(1));
                        end else begin
                            cntr  <= '0;
                            last  <= 1'b0;
                            state <= ST_IDLE;
                        end
                    end
`endif
                    else if (hold) begin
                        cntr <= cntr;
                    end else if (cntr < max_sh) begin
                        cntr <= cntr_inc;
                        last <= (cntr_inc == max_sh);
                    end else if (mode_sh == CNT_CONT && enable) begin
                        cntr <= COUNT_WIDTH'(1);
                        last <= (max_sh == COUNT_WIDTH'(1));
                    end else begin
                        cntr  <= '0;
                        last  <= 1'b0;
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/jb_cntr_p2s_mc.sv
// Multi-channel P2S sequence counter; channels are fully independent.
// JB_CNTR_P2S_MC_RETRIG_EN enables restart-on-rising-enable during RUN.
module jb_cntr_p2s_mc
    import jb_cntr_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int COUNT_WIDTH = DEF_COUNT_WIDTH
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_CH-1:0]             enable,
    input  logic [NUM_CH-1:0]             stop,
    input  logic [NUM_CH-1:0]             hold,
    input  logic [NUM_CH-1:0]             mode,
    input  logic [NUM_CH*COUNT_WIDTH-1:0] max_value,
    output logic [NUM_CH*COUNT_WIDTH-1:0] cntr,
    output logic [NUM_CH-1:0]             busy,
    output logic [NUM_CH-1:0]             last
);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        jb_cntr_p2s_ch #(
            .COUNT_WIDTH(COUNT_WIDTH)
        ) u_ch (
            .clk      (clk),
            .reset    (reset),
            .enable   (enable[i]),
            .stop     (stop[i]),
            .hold     (hold[i]),
            .mode     (mode[i]),
            .max_value(max_value[i*COUNT_WIDTH +: COUNT_WIDTH]),
            .cntr     (cntr[i*COUNT_WIDTH +: COUNT_WIDTH]),
            .busy     (busy[i]),
            .last     (last[i])
        );
    end

endmodule

// File: tb/tb_jb_cntr_p2s_mc.sv
// Scoreboard bench for jb_cntr_p2s_mc (4 channels, 8-bit counters).
module tb_jb_cntr_p2s_mc;

    localparam int NCH = 4;
    localparam int W   = 8;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic [NCH-1:0] enable = 4'b1000;
    logic [NCH-1:0] stop = '0;
    logic [NCH-1:0] hold = '0;
    logic [NCH-1:0] mode = '0;
    logic [NCH*W-1:0] max_value = '0;
    logic [NCH*W-1:0] cntr;
    logic [NCH-1:0] busy;
    logic [NCH-1:0] last;

    int cyc = 0;
    int checks = 0;
    int failures = 0;

    typedef struct {
        int    cyc;
        int    ch;
        int    cnt;
        bit    b;
        bit    l;
        string nm;
    } exp_t;

    exp_t sb[$];

    jb_cntr_p2s_mc #(
        .NUM_CH(NCH),
        .COUNT_WIDTH(W)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .enable   (enable),
        .stop     (stop),
        .hold     (hold),
        .mode     (mode),
        .max_value(max_value),
        .cntr     (cntr),
        .busy     (busy),
        .last     (last)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic expect_at(input int c, input int ch, input int cnt,
                             input bit b, input bit l, input string nm);
        exp_t e;
        e.cyc = c;
        e.ch  = ch;
        e.cnt = cnt;
        e.b   = b;
        e.l   = l;
        e.nm  = nm;
        sb.push_back(e);
    endtask

    task automatic idle_at(input int c, input int ch, input string nm);
        expect_at(c, ch, 0, 1'b0, 1'b0, nm);
    endtask

    task automatic at(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_max(input int ch, input int v);
        max_value[ch*W +: W] = v[W-1:0];
    endtask

    // Monitor: compares every expectation due in the current cycle.
    always @(negedge clk) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc == cyc) begin
                logic [W-1:0] a_c;
                logic         a_b;
                logic         a_l;
                a_c = cntr[sb[i].ch*W +: W];
                a_b = busy[sb[i].ch];
                a_l = last[sb[i].ch];
                checks++;
                if (a_c !== sb[i].cnt[W-1:0] || a_b !== sb[i].b
                    || a_l !== sb[i].l) begin
                    failures++;
                    $display("FAIL %s cyc=%0d ch=%0d got cntr=%0d busy=%b last=%b want cntr=%0d busy=%b last=%b",
                             sb[i].nm, cyc, sb[i].ch, a_c, a_b, a_l,
                             sb[i].cnt, sb[i].b, sb[i].l);
                end
                sb.delete(i);
            end else if (sb[i].cyc < cyc) begin
                failures++;
                $display("FAIL %s missed cyc=%0d ch=%0d",
                         sb[i].nm, sb[i].cyc, sb[i].ch);
                sb.delete(i);
            end
        end
    end

    initial begin
        set_max(3, 4);
        for (int ch = 0; ch < NCH; ch++) idle_at(1, ch, "reset");

        at(2);
        reset = 1'b0;
        for (int ch = 0; ch < NCH - 1; ch++) idle_at(2, ch, "reset_rel");
        for (int c = 2; c <= 4; c++) idle_at(c, 3, "en_thru_rst");

        at(5);
        enable[3] = 1'b0;
        idle_at(6, 3, "en_thru_rst_low");

        at(10);
        set_max(0, 5);
        mode[0] = 1'b0;
        set_max(1, 3);
        mode[1] = 1'b1;
        enable[1:0] = 2'b11;
        idle_at(10, 0, "oneshot5_pre");
        for (int c = 11; c <= 15; c++)
            expect_at(c, 0, c - 10, 1'b1, c == 15, "oneshot5");
        idle_at(16, 0, "oneshot5_end");
        idle_at(17, 0, "oneshot5_end");
        for (int c = 11; c <= 22; c++) begin
            int v;
            v = (c - 11) % 3 + 1;
            expect_at(c, 1, v, 1'b1, v == 3, "cont3");
        end
        idle_at(23, 1, "cont3_end");

        at(20);
        enable[1:0] = 2'b00;
        set_max(0, 0);

        at(22);
        enable[0] = 1'b1;
        idle_at(23, 0, "max0");
        idle_at(24, 0, "max0");

        at(25);
        enable[0] = 1'b0;
        set_max(0, 1);

        at(30);
        enable[0] = 1'b1;
        set_max(2, 4);
        mode[2] = 1'b0;
        enable[2] = 1'b1;
        expect_at(31, 0, 1, 1'b1, 1'b1, "max1");
        idle_at(32, 0, "max1_end");
        expect_at(31, 2, 1, 1'b1, 1'b0, "hold");
        for (int c = 32; c <= 35; c++)
            expect_at(c, 2, 2, 1'b1, 1'b0, "hold");
        expect_at(36, 2, 3, 1'b1, 1'b0, "hold");
        expect_at(37, 2, 4, 1'b1, 1'b1, "hold");
        idle_at(38, 2, "hold_end");

        at(32);
        hold[2] = 1'b1;
        at(33);
        enable[0] = 1'b0;
        at(35);
        hold[2] = 1'b0;
        at(38);
        enable[2] = 1'b0;

        at(40);
        enable[2] = 1'b1;
        for (int c = 41; c <= 43; c++)
            expect_at(c, 2, c - 40, 1'b1, 1'b0, "stop");
        idle_at(44, 2, "stop_end");
        idle_at(45, 2, "stop_end");
        at(43);
        stop[2] = 1'b1;
        at(44);
        stop[2] = 1'b0;
        at(45);
        enable[2] = 1'b0;

        at(50);
        set_max(1, 1);
        mode[1] = 1'b1;
        enable[1] = 1'b1;
        set_max(3, 255);
        mode[3] = 1'b0;
        enable[3] = 1'b1;
        for (int c = 51; c <= 55; c++)
            expect_at(c, 1, 1, 1'b1, 1'b1, "cont1");
        idle_at(56, 1, "cont1_end");
        expect_at(51, 3, 1, 1'b1, 1'b0, "max255");
        expect_at(52, 3, 2, 1'b1, 1'b0, "max255");
        expect_at(304, 3, 254, 1'b1, 1'b0, "max255");
        expect_at(305, 3, 255, 1'b1, 1'b1, "max255");
        idle_at(306, 3, "max255_end");

        at(55);
        enable[1] = 1'b0;

        at(60);
        set_max(0, 6);
        mode[0] = 1'b0;
        enable[0] = 1'b1;
        enable[3] = 1'b0;
        expect_at(61, 0, 1, 1'b1, 1'b0, "retrig");
        expect_at(62, 0, 2, 1'b1, 1'b0, "retrig");
        at(61);
        enable[0] = 1'b0;
        at(62);
        enable[0] = 1'b1;
        set_max(0, 2);
`ifdef JB_CNTR_P2S_MC_RETRIG_EN
        expect_at(63, 0, 1, 1'b1, 1'b0, "retrig");
        expect_at(64, 0, 2, 1'b1, 1'b1, "retrig");
        idle_at(65, 0, "retrig_end");
`else
        for (int c = 63; c <= 66; c++)
            expect_at(c, 0, c - 60, 1'b1, c == 66, "retrig");
        idle_at(67, 0, "retrig_end");
`endif

        at(70);
        set_max(2, 4);
        enable[2] = 1'b1;
        stop[2] = 1'b1;
        idle_at(71, 2, "start_stop");
        idle_at(72, 2, "start_stop");
        at(71);
        stop[2] = 1'b0;
        enable[0] = 1'b0;
        at(75);
        enable[2] = 1'b0;

        at(310);
        enable = '0;

        at(312);
        for (int ch = 0; ch < NCH; ch++) set_max(ch, 10);
        mode = 4'b0010;
        enable = '1;
        for (int ch = 0; ch < NCH; ch++) begin
            expect_at(313, ch, 1, 1'b1, 1'b0, "allrun");
            expect_at(314, ch, 2, 1'b1, 1'b0, "allrun");
        end

        at(315);
        reset = 1'b1;
        for (int ch = 0; ch < NCH; ch++) begin
            idle_at(315, ch, "rst_mid");
            idle_at(316, ch, "rst_mid");
        end

        at(317);
        reset = 1'b0;
        for (int ch = 0; ch < NCH; ch++) begin
            idle_at(318, ch, "rst_rel");
            idle_at(319, ch, "rst_rel");
        end

        at(322);
        foreach (sb[i]) begin
            failures++;
            $display("FAIL %s unchecked cyc=%0d ch=%0d",
                     sb[i].nm, sb[i].cyc, sb[i].ch);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
